// File: rtl/div_period_meter.sv
// div_period_meter: measures the period and high time of a slow square wave
// in system clock cycles and reports one measurement per input period.
module div_period_meter #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [0:0] {StIdle, StMeasure} state_e;

    localparam logic [CNT_W-1:0] CntMax     = '1;
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

    logic             s1_q, s2_q, d_q;
    logic             rise, fall;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hs_q, hs_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             mv_q, mv_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    // Two-flop synchroniser followed by a delay flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            d_q  <= 1'b0;
        end else begin
            s1_q <= div_in;
            s2_q <= s1_q;
            d_q  <= s2_q;
        end
    end

    assign rise = s2_q & ~d_q;
    assign fall = ~s2_q & d_q;

    // State, counter, shadow and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hs_q      <= '0;
            period_q  <= '0;
            high_q    <= '0;
            mv_q      <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hs_q      <= hs_d;
            period_q  <= period_d;
            high_q    <= high_d;
            mv_q      <= mv_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: a rise restarts the count; fall is handled before rise
    // so a degenerate period without a fall reports high_time = 0.
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
        hs_d      = hs_q;
        period_d  = period_q;
        high_d    = high_q;
        mv_d      = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;

        if (rise) begin
            cnt_d = CntOne;
        end

        case (state_q)
            StIdle: begin
                // Fall is ignored here; the first rise only arms the block.
                if (rise) begin
                    hs_d    = '0;
                    state_d = StMeasure;
                end
            end
            StMeasure: begin
                if (fall) begin
                    hs_d = cnt_q;
                end
                if (rise) begin
                    // Rise wins over a coincident timeout.
                    period_d  = cnt_q;
                    high_d    = hs_q;
                    mv_d      = 1'b1;
                    locked_d  = 1'b1;
                    timeout_d = 1'b0;
                    hs_d      = '0;
                end else if (cnt_q == TimeoutVal) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = mv_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule
